// File: rtl/op_fwd_mux.sv
// op_fwd_mux: resolves one source operand from N forwarding stages, the
// register-file read value, or a forced zero, and registers it into a
// 2-entry skid buffer with valid/ready handshakes on both sides.
//
// Optional feature macro: OP_FWD_ZERO_REG_EN
//   defined   -> src_idx==0 is the hardwired zero register x0 and never
//                forwards. Stage entries with fwd_idx==0 never match.
//   undefined -> index 0 is an ordinary register.
`timescale 1ns/1ps

module op_fwd_mux #(
  parameter int OP_W  = 32,
  parameter int IDX_W = 5,
  parameter int N_FWD = 3,
  parameter int SRC_W = $clog2(N_FWD + 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       src_idx,
  input  logic                   zero_sel,
  input  logic [OP_W-1:0]        rf_data,
  input  logic [N_FWD-1:0]       fwd_valid,
  input  logic [N_FWD*IDX_W-1:0] fwd_idx,
  input  logic [N_FWD*OP_W-1:0]  fwd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_W-1:0]        out_data,
  output logic [SRC_W-1:0]       out_src
);

  // Provenance tags; forwarding stage k is tagged 2+k.
  localparam logic [SRC_W-1:0] SRC_ZERO = '0;
  localparam logic [SRC_W-1:0] SRC_RF   = SRC_W'(1);

  // ---------------------------------------------------------------------
  // Input-side operand selection
  // ---------------------------------------------------------------------
  logic [N_FWD-1:0] fwd_hit;
  logic             x0_hit;
  logic [OP_W-1:0]  sel_data;
  logic [SRC_W-1:0] sel_src;

`ifdef OP_FWD_ZERO_REG_EN
  // x0 is architecturally zero, so it can never be a forwarding target.
  assign x0_hit = (src_idx == '0);
`else
  assign x0_hit = 1'b0;
`endif

  // Per-stage match: entry valid and destination equals the source index.
  generate
    for (genvar gi = 0; gi < N_FWD; gi++) begin : g_hit
`ifdef OP_FWD_ZERO_REG_EN
      assign fwd_hit[gi] = fwd_valid[gi]
                         && (fwd_idx[gi*IDX_W +: IDX_W] == src_idx)
                         && (fwd_idx[gi*IDX_W +: IDX_W] != '0);
`else
      assign fwd_hit[gi] = fwd_valid[gi]
                         && (fwd_idx[gi*IDX_W +: IDX_W] == src_idx);
`endif
    end
  endgenerate

  // Priority mux: forced zero, then youngest matching stage, then rf_data.
  always_comb begin
    sel_data = rf_data;
    sel_src  = SRC_RF;
    // Walk from oldest to youngest so the youngest match overrides.
    for (int k = N_FWD - 1; k >= 0; k--) begin
      if (fwd_hit[k]) begin
        sel_data = fwd_data[k*OP_W +: OP_W];
        sel_src  = SRC_W'(k + 2);
      end
    end
    if (zero_sel || x0_hit) begin
      sel_data = '0;
      sel_src  = SRC_ZERO;
    end
  end

  // ---------------------------------------------------------------------
  // Two-entry skid buffer: M drives the outputs, S absorbs one extra
  // operand when downstream stalls. in_ready depends only on S, so there
  // is no combinational path from out_ready to in_ready.
  // ---------------------------------------------------------------------
  logic             m_valid_reg, m_valid_next;
  logic [OP_W-1:0]  m_data_reg,  m_data_next;
  logic [SRC_W-1:0] m_src_reg,   m_src_next;
  logic             s_valid_reg, s_valid_next;
  logic [OP_W-1:0]  s_data_reg,  s_data_next;
  logic [SRC_W-1:0] s_src_reg,   s_src_next;

  logic accept;
  logic xfer;

  assign in_ready  = !s_valid_reg;
  assign accept    = in_valid && in_ready;
  assign xfer      = m_valid_reg && out_ready;

  assign out_valid = m_valid_reg;
  assign out_data  = m_data_reg;
  assign out_src   = m_src_reg;

  // Next-state logic for the EMPTY / ONE / FULL occupancy cases.
  always_comb begin
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    m_src_next   = m_src_reg;
    s_valid_next = s_valid_reg;
    s_data_next  = s_data_reg;
    s_src_next   = s_src_reg;

    if (!m_valid_reg) begin
      // EMPTY: a new operand goes straight into M.
      if (accept) begin
        m_valid_next = 1'b1;
        m_data_next  = sel_data;
        m_src_next   = sel_src;
      end
    end else if (!s_valid_reg) begin
      // ONE: replace, park in S, drain, or hold.
      if (accept && xfer) begin
        m_data_next  = sel_data;
        m_src_next   = sel_src;
      end else if (accept) begin
        s_valid_next = 1'b1;
        s_data_next  = sel_data;
        s_src_next   = sel_src;
      end else if (xfer) begin
        m_valid_next = 1'b0;
      end
    end else begin
      // FULL: no accept possible; a transfer promotes S into M.
      if (xfer) begin
        m_data_next  = s_data_reg;
        m_src_next   = s_src_reg;
        s_valid_next = 1'b0;
      end
    end
  end

  // State registers; reset discards both entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_src_reg   <= '0;
      s_valid_reg <= 1'b0;
      s_data_reg  <= '0;
      s_src_reg   <= '0;
    end else begin
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      m_src_reg   <= m_src_next;
      s_valid_reg <= s_valid_next;
      s_data_reg  <= s_data_next;
      s_src_reg   <= s_src_next;
    end
  end

endmodule

// File: tb/tb_op_fwd_mux.sv
// Testbench for op_fwd_mux: directed scenarios followed by random traffic,
// all checked against a FIFO-of-operands reference model.
// Honors OP_FWD_ZERO_REG_EN the same way as the design.
`timescale 1ns/1ps

module tb_op_fwd_mux;

  localparam int OP_W  = 32;
  localparam int IDX_W = 5;
  localparam int N_FWD = 3;
  localparam int SRC_W = $clog2(N_FWD + 2);

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [IDX_W-1:0]       src_idx;
  logic                   zero_sel;
  logic [OP_W-1:0]        rf_data;
  logic [N_FWD-1:0]       fwd_valid;
  logic [N_FWD*IDX_W-1:0] fwd_idx;
  logic [N_FWD*OP_W-1:0]  fwd_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OP_W-1:0]        out_data;
  logic [SRC_W-1:0]       out_src;

  op_fwd_mux #(.OP_W(OP_W), .IDX_W(IDX_W), .N_FWD(N_FWD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_idx   (src_idx),
    .zero_sel  (zero_sel),
    .rf_data   (rf_data),
    .fwd_valid (fwd_valid),
    .fwd_idx   (fwd_idx),
    .fwd_data  (fwd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]  d;
    logic [SRC_W-1:0] s;
  } op_t;

  op_t q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference resolution straight from the priority rules.
  task automatic ref_sel(output logic [OP_W-1:0] d, output logic [SRC_W-1:0] s);
    d = rf_data;
    s = 1;
    if (zero_sel) begin
      d = 0; s = 0; return;
    end
`ifdef OP_FWD_ZERO_REG_EN
    if (src_idx == 0) begin
      d = 0; s = 0; return;
    end
`endif
    for (int k = 0; k < N_FWD; k++) begin
      if (fwd_valid[k] && fwd_idx[k*IDX_W +: IDX_W] == src_idx) begin
        d = fwd_data[k*OP_W +: OP_W];
        s = SRC_W'(k + 2);
        return;
      end
    end
  endtask

  // One clock: check outputs against the model at the falling edge,
  // predict handshakes, then update the model after the rising edge.
  task automatic cycle();
    logic acc, xf;
    op_t  e;
    @(negedge clk);
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      check("out_data", out_data, q[0].d);
      check("out_src", out_src, q[0].s);
    end
    acc = in_valid && (q.size() < 2);
    xf  = out_ready && (q.size() > 0);
    ref_sel(e.d, e.s);
    @(posedge clk);
    #1;
    if (xf)  void'(q.pop_front());
    if (acc) q.push_back(e);
    $display("t=%0t acc=%0d xfer=%0d occ=%0d out_valid=%0d out_data=%0h out_src=%0d",
             $time, acc, xf, q.size(), out_valid, out_data, out_src);
  endtask

  task automatic idle_inputs();
    in_valid  = 0;
    zero_sel  = 0;
    src_idx   = 0;
    rf_data   = 0;
    fwd_valid = 0;
    fwd_idx   = 0;
    fwd_data  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    idle_inputs();
    out_ready = 0;
    rst_n     = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    rst_n = 1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Forward priority: stages 1 and 2 both match, stage 1 wins
    out_ready = 1;
    in_valid  = 1;
    src_idx   = 5;
    fwd_valid = 3'b110;
    fwd_idx   = {5'd5, 5'd5, 5'd7};
    fwd_data  = {32'hCCCC, 32'hBBBB, 32'hAAAA};
    rf_data   = 32'h1111;
    cycle();
    check("prio_data", out_data, 32'hBBBB);
    check("prio_src", out_src, 3);

    // No match then forced zero
    src_idx   = 9;
    rf_data   = 32'h1234;
    cycle();
    check("nomatch_data", out_data, 32'h1234);
    check("nomatch_src", out_src, 1);
    zero_sel  = 1;
    cycle();
    check("zero_data", out_data, 0);
    check("zero_src", out_src, 0);
    zero_sel  = 0;
    in_valid  = 0;
    cycle();
    check("drained", out_valid, 0);

    // Backpressure: fill M and S, third request refused
    idle_inputs();
    out_ready = 0;
    in_valid  = 1;
    src_idx   = 9;
    rf_data   = 32'h1;
    cycle();
    rf_data   = 32'h2;
    cycle();
    check("bp_in_ready", in_ready, 0);
    check("bp_m", out_data, 32'h1);
    rf_data   = 32'h3;
    cycle();
    check("bp_hold", out_data, 32'h1);
    out_ready = 1;
    cycle();
    check("bp_second", out_data, 32'h2);
    check("bp_ready_back", in_ready, 1);
    cycle();
    check("bp_third", out_data, 32'h3);
    in_valid  = 0;
    cycle();
    check("bp_empty", out_valid, 0);

    // Hold stability: stage-0 capture survives fwd_data changes
    out_ready = 0;
    in_valid  = 1;
    src_idx   = 4;
    fwd_valid = 3'b001;
    fwd_idx   = {5'd0, 5'd0, 5'd4};
    fwd_data  = {32'h0, 32'h0, 32'h5A5A5A5A};
    cycle();
    in_valid  = 0;
    for (int i = 0; i < 3; i++) begin
      fwd_data = {3{$urandom()}};
      cycle();
      check("hold_data", out_data, 32'h5A5A5A5A);
      check("hold_src", out_src, 2);
    end
    out_ready = 1;
    cycle();

    // Reset mid-operation with the skid FULL
    idle_inputs();
    out_ready = 0;
    in_valid  = 1;
    rf_data   = 32'h10;
    src_idx   = 9;
    cycle();
    rf_data   = 32'h20;
    cycle();
    in_valid  = 0;
    check("full_in_ready", in_ready, 0);
    #2;
    rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1;
    #1;
    in_valid  = 1;
    rf_data   = 32'h77;
    out_ready = 1;
    cycle();
    check("postrst_valid", out_valid, 1);
    check("postrst_data", out_data, 32'h77);
    in_valid  = 0;
    cycle();

    // x0 handling
    idle_inputs();
    in_valid  = 1;
    src_idx   = 0;
    fwd_valid = 3'b001;
    fwd_idx   = 0;
    fwd_data  = {32'h0, 32'h0, 32'hDEAD};
    rf_data   = 32'hBEEF;
    cycle();
`ifdef OP_FWD_ZERO_REG_EN
    check("x0_data", out_data, 0);
    check("x0_src", out_src, 0);
`else
    check("x0_data", out_data, 32'hDEAD);
    check("x0_src", out_src, 2);
`endif
    in_valid = 0;
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      zero_sel  = ($urandom_range(0, 7) == 0);
      src_idx   = IDX_W'($urandom_range(0, 5));
      rf_data   = $urandom();
      fwd_valid = N_FWD'($urandom());
      for (int k = 0; k < N_FWD; k++) begin
        fwd_idx[k*IDX_W +: IDX_W]  = IDX_W'($urandom_range(0, 5));
        fwd_data[k*OP_W +: OP_W]   = $urandom();
      end
      cycle();
    end

    // Drain
    idle_inputs();
    out_ready = 1;
    repeat (3) cycle();
    check("final_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
